// File: rtl/noc_tg_pkg.sv
// rtl/noc_tg_pkg.sv - shared flit type, controller states and edge id helpers for the self-testing mesh
package noc_tg_pkg;

    localparam int FLIT_W = 32;

    typedef struct packed {
        logic [7:0]  dest;
        logic [7:0]  src;
        logic [15:0] seq;
    } flit_t;

    typedef enum logic [1:0] {
        TG_IDLE,
        TG_RUN,
        TG_PASS,
        TG_FAIL
    } tg_state_t;

    function automatic int west_id(input int r);
        return r;
    endfunction

    function automatic int east_id(input int h, input int r);
        return h + r;
    endfunction

    function automatic int north_id(input int h, input int c);
        return 2 * h + c;
    endfunction

    function automatic int south_id(input int h, input int w, input int c);
        return 2 * h + w + c;
    endfunction

    function automatic int n_edge(input int h, input int w);
        return 2 * (h + w);
    endfunction

endpackage

// File: rtl/noc_edge_tg.sv
// rtl/noc_edge_tg.sv - per-edge traffic generator toward the opposite edge plus in-order checker of arriving flits
module noc_edge_tg
    import noc_tg_pkg::*;
#(
    parameter int MY_ID     = 0,
    parameter int PEER_ID   = 0,
    parameter int PKT_COUNT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              run,
    output logic              up_valid,
    input  logic              up_ready,
    output logic [FLIT_W-1:0] up_data,
    input  logic              down_valid,
    output logic              down_ready,
    input  logic [FLIT_W-1:0] down_data,
    output logic              tx_done,
    output logic              rx_done,
    output logic              chk_err,
    output logic              accept
);

    localparam int            CW   = 17;
    localparam logic [CW-1:0] LAST = CW'(PKT_COUNT);

    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;
    flit_t         tx_flit;
    flit_t         rx_flit;
    logic          rx_bad;

    assign tx_done = (tx_cnt == LAST);
    assign rx_done = (rx_cnt == LAST);

    // Valid is gated by run so leaving RUN abandons any pending handshake at once.
    assign up_valid = run && !tx_done;

    always_comb begin
        tx_flit      = '0;
        tx_flit.dest = 8'(PEER_ID);
        tx_flit.src  = 8'(MY_ID);
        tx_flit.seq  = tx_cnt[15:0];
    end

    assign up_data    = tx_flit;
    assign down_ready = run;
    assign accept     = down_valid && run;
    assign rx_flit    = flit_t'(down_data);

    // A flit after the full count is as wrong as a misaddressed or out-of-order one.
    assign rx_bad = rx_done
                 || (rx_flit.dest != 8'(MY_ID))
                 || (rx_flit.src  != 8'(PEER_ID))
                 || (rx_flit.seq  != rx_cnt[15:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            chk_err <= 1'b0;
        end else if (go) begin
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            chk_err <= 1'b0;
        end else begin
            if (up_valid && up_ready) tx_cnt <= tx_cnt + CW'(1);
            if (accept) begin
                if (rx_bad)   chk_err <= 1'b1;
                if (!rx_done) rx_cnt  <= rx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/noc_mesh.sv
// rtl/noc_mesh.sv - XY-routed mesh fabric; edge-to-opposite-edge traffic never turns, so each row and column is a pair of lanes
module noc_mesh
    import noc_tg_pkg::*;
#(
    parameter int MESH_WIDTH  = 2,
    parameter int MESH_HEIGHT = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic [MESH_HEIGHT-1:0]                west_up_valid,
    output logic [MESH_HEIGHT-1:0]                west_up_ready,
    input  logic [MESH_HEIGHT-1:0][FLIT_W-1:0]    west_up_data,
    output logic [MESH_HEIGHT-1:0]                west_down_valid,
    input  logic [MESH_HEIGHT-1:0]                west_down_ready,
    output logic [MESH_HEIGHT-1:0][FLIT_W-1:0]    west_down_data,
    input  logic [MESH_HEIGHT-1:0]                east_up_valid,
    output logic [MESH_HEIGHT-1:0]                east_up_ready,
    input  logic [MESH_HEIGHT-1:0][FLIT_W-1:0]    east_up_data,
    output logic [MESH_HEIGHT-1:0]                east_down_valid,
    input  logic [MESH_HEIGHT-1:0]                east_down_ready,
    output logic [MESH_HEIGHT-1:0][FLIT_W-1:0]    east_down_data,
    input  logic [MESH_WIDTH-1:0]                 north_up_valid,
    output logic [MESH_WIDTH-1:0]                 north_up_ready,
    input  logic [MESH_WIDTH-1:0][FLIT_W-1:0]     north_up_data,
    output logic [MESH_WIDTH-1:0]                 north_down_valid,
    input  logic [MESH_WIDTH-1:0]                 north_down_ready,
    output logic [MESH_WIDTH-1:0][FLIT_W-1:0]     north_down_data,
    input  logic [MESH_WIDTH-1:0]                 south_up_valid,
    output logic [MESH_WIDTH-1:0]                 south_up_ready,
    input  logic [MESH_WIDTH-1:0][FLIT_W-1:0]     south_up_data,
    output logic [MESH_WIDTH-1:0]                 south_down_valid,
    input  logic [MESH_WIDTH-1:0]                 south_down_ready,
    output logic [MESH_WIDTH-1:0][FLIT_W-1:0]     south_down_data
);

    for (genvar r = 0; r < MESH_HEIGHT; r++) begin : g_row
        noc_mesh_lane #(.DEPTH(MESH_WIDTH)) u_eastbound (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(west_up_valid[r]), .in_ready(west_up_ready[r]), .in_data(west_up_data[r]),
            .out_valid(east_down_valid[r]), .out_ready(east_down_ready[r]), .out_data(east_down_data[r])
        );
        noc_mesh_lane #(.DEPTH(MESH_WIDTH)) u_westbound (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(east_up_valid[r]), .in_ready(east_up_ready[r]), .in_data(east_up_data[r]),
            .out_valid(west_down_valid[r]), .out_ready(west_down_ready[r]), .out_data(west_down_data[r])
        );
    end

    for (genvar c = 0; c < MESH_WIDTH; c++) begin : g_col
        noc_mesh_lane #(.DEPTH(MESH_HEIGHT)) u_southbound (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(north_up_valid[c]), .in_ready(north_up_ready[c]), .in_data(north_up_data[c]),
            .out_valid(south_down_valid[c]), .out_ready(south_down_ready[c]), .out_data(south_down_data[c])
        );
        noc_mesh_lane #(.DEPTH(MESH_HEIGHT)) u_northbound (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(south_up_valid[c]), .in_ready(south_up_ready[c]), .in_data(south_up_data[c]),
            .out_valid(north_down_valid[c]), .out_ready(north_down_ready[c]), .out_data(north_down_data[c])
        );
    end

endmodule

// File: rtl/noc_mesh_lane.sv
// rtl/noc_mesh_lane.sv - straight chain of DEPTH one-flit hop registers, one register per mesh node
module noc_mesh_lane
    import noc_tg_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_data
);

    logic [DEPTH-1:0]             vq;
    logic [DEPTH-1:0]             vin;
    logic [DEPTH-1:0]             rdy;
    logic [DEPTH-1:0][FLIT_W-1:0] dq;
    logic [DEPTH-1:0][FLIT_W-1:0] din;

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        vin    = '0;
        din    = '0;
        rdy    = '0;
        vin[0] = in_valid;
        din[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            vin[i] = vq[i-1];
            din[i] = dq[i-1];
        end
        rdy[DEPTH-1] = !vq[DEPTH-1] || out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = !vq[i] || rdy[i+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq <= '0;
        end else if (flush) begin
            vq <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) vq[i] <= vin[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && vin[i]) dq[i] <= din[i];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vq[DEPTH-1];
    assign out_data  = dq[DEPTH-1];

endmodule

// File: rtl/noc_mesh_tg_top.sv
// rtl/noc_mesh_tg_top.sv - self-testing mesh: edge generators/checkers on every boundary port and a run controller
module noc_mesh_tg_top
    import noc_tg_pkg::*;
#(
    parameter int MESH_WIDTH  = 2,
    parameter int MESH_HEIGHT = 2,
    parameter int PKT_COUNT   = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        err_timeout,
    output logic [31:0] rx_total
);

    localparam int W      = MESH_WIDTH;
    localparam int H      = MESH_HEIGHT;
    localparam int N_EDGE = n_edge(H, W);

    tg_state_t         state_q, state_d;
    logic              go, run, set_tmo, tmo_q, tmo_hit, all_done, any_err;
    logic [31:0]       tmo_cnt, acc_sum;
    logic [N_EDGE-1:0] tx_done, rx_done, chk_err, accept;

    logic [H-1:0]             west_up_valid, west_up_ready, west_down_valid, west_down_ready;
    logic [H-1:0]             east_up_valid, east_up_ready, east_down_valid, east_down_ready;
    logic [W-1:0]             north_up_valid, north_up_ready, north_down_valid, north_down_ready;
    logic [W-1:0]             south_up_valid, south_up_ready, south_down_valid, south_down_ready;
    logic [H-1:0][FLIT_W-1:0] west_up_data, west_down_data, east_up_data, east_down_data;
    logic [W-1:0][FLIT_W-1:0] north_up_data, north_down_data, south_up_data, south_down_data;

    assign run         = (state_q == TG_RUN);
    assign busy        = run;
    assign done        = (state_q == TG_PASS);
    assign error       = (state_q == TG_FAIL);
    assign err_timeout = tmo_q;
    assign all_done    = &{tx_done, rx_done};
    assign any_err     = |chk_err;
    assign tmo_hit     = (tmo_cnt == 32'(TIMEOUT - 1));

    // Check errors outrank completion; completion outranks timeout.
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        set_tmo = 1'b0;
        case (state_q)
            TG_RUN: begin
                if (any_err) begin
                    state_d = TG_FAIL;
                end else if (all_done) begin
                    state_d = TG_PASS;
                end else if (tmo_hit) begin
                    state_d = TG_FAIL;
                    set_tmo = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d = TG_RUN;
                    go      = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < N_EDGE; i++) begin
            acc_sum = acc_sum + 32'(accept[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= TG_IDLE;
            tmo_cnt  <= '0;
            tmo_q    <= 1'b0;
            rx_total <= '0;
        end else begin
            state_q <= state_d;
            if (go) begin
                tmo_cnt  <= '0;
                tmo_q    <= 1'b0;
                rx_total <= '0;
            end else begin
                if (run && (tmo_cnt != '1)) tmo_cnt <= tmo_cnt + 32'd1;
                if (set_tmo) tmo_q <= 1'b1;
                rx_total <= rx_total + acc_sum;
            end
        end
    end

    for (genvar r = 0; r < H; r++) begin : g_row
        localparam int WID = west_id(r);
        localparam int EID = east_id(H, r);
        noc_edge_tg #(.MY_ID(WID), .PEER_ID(EID), .PKT_COUNT(PKT_COUNT)) u_west (
            .clk(clk), .rst_n(rst), .go(go), .run(run),
            .up_valid(west_up_valid[r]), .up_ready(west_up_ready[r]), .up_data(west_up_data[r]),
            .down_valid(west_down_valid[r]), .down_ready(west_down_ready[r]), .down_data(west_down_data[r]),
            .tx_done(tx_done[WID]), .rx_done(rx_done[WID]), .chk_err(chk_err[WID]), .accept(accept[WID])
        );
        noc_edge_tg #(.MY_ID(EID), .PEER_ID(WID), .PKT_COUNT(PKT_COUNT)) u_east (
            .clk(clk), .rst_n(rst), .go(go), .run(run),
            .up_valid(east_up_valid[r]), .up_ready(east_up_ready[r]), .up_data(east_up_data[r]),
            .down_valid(east_down_valid[r]), .down_ready(east_down_ready[r]), .down_data(east_down_data[r]),
            .tx_done(tx_done[EID]), .rx_done(rx_done[EID]), .chk_err(chk_err[EID]), .accept(accept[EID])
        );
    end

    for (genvar c = 0; c < W; c++) begin : g_col
        localparam int NID = north_id(H, c);
        localparam int SID = south_id(H, W, c);
        noc_edge_tg #(.MY_ID(NID), .PEER_ID(SID), .PKT_COUNT(PKT_COUNT)) u_north (
            .clk(clk), .rst_n(rst), .go(go), .run(run),
            .up_valid(north_up_valid[c]), .up_ready(north_up_ready[c]), .up_data(north_up_data[c]),
            .down_valid(north_down_valid[c]), .down_ready(north_down_ready[c]), .down_data(north_down_data[c]),
            .tx_done(tx_done[NID]), .rx_done(rx_done[NID]), .chk_err(chk_err[NID]), .accept(accept[NID])
        );
        noc_edge_tg #(.MY_ID(SID), .PEER_ID(NID), .PKT_COUNT(PKT_COUNT)) u_south (
            .clk(clk), .rst_n(rst), .go(go), .run(run),
            .up_valid(south_up_valid[c]), .up_ready(south_up_ready[c]), .up_data(south_up_data[c]),
            .down_valid(south_down_valid[c]), .down_ready(south_down_ready[c]), .down_data(south_down_data[c]),
            .tx_done(tx_done[SID]), .rx_done(rx_done[SID]), .chk_err(chk_err[SID]), .accept(accept[SID])
        );
    end

    // Flits stranded by a failed run are dropped when the next run starts.
    noc_mesh #(.MESH_WIDTH(W), .MESH_HEIGHT(H)) u_mesh (
        .clk(clk), .rst_n(rst), .flush(go),
        .west_up_valid(west_up_valid), .west_up_ready(west_up_ready), .west_up_data(west_up_data),
        .west_down_valid(west_down_valid), .west_down_ready(west_down_ready), .west_down_data(west_down_data),
        .east_up_valid(east_up_valid), .east_up_ready(east_up_ready), .east_up_data(east_up_data),
        .east_down_valid(east_down_valid), .east_down_ready(east_down_ready), .east_down_data(east_down_data),
        .north_up_valid(north_up_valid), .north_up_ready(north_up_ready), .north_up_data(north_up_data),
        .north_down_valid(north_down_valid), .north_down_ready(north_down_ready), .north_down_data(north_down_data),
        .south_up_valid(south_up_valid), .south_up_ready(south_up_ready), .south_up_data(south_up_data),
        .south_down_valid(south_down_valid), .south_down_ready(south_down_ready), .south_down_data(south_down_data)
    );

endmodule

// File: tb/tb_noc_mesh_tg_top.sv
// tb/tb_noc_mesh_tg_top.sv - directed scenario bench for the self-testing mesh top
module tb_noc_mesh_tg_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, start_c;
    logic        busy_a, done_a, error_a, tmo_a;
    logic        busy_b, done_b, error_b, tmo_b;
    logic        busy_c, done_c, error_c, tmo_c;
    logic [31:0] rx_a, rx_b, rx_c;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    noc_mesh_tg_top dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .error(error_a), .err_timeout(tmo_a), .rx_total(rx_a)
    );

    noc_mesh_tg_top #(.MESH_WIDTH(3), .MESH_HEIGHT(4), .PKT_COUNT(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .error(error_b), .err_timeout(tmo_b), .rx_total(rx_b)
    );

    noc_mesh_tg_top #(.PKT_COUNT(1000), .TIMEOUT(200)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .error(error_c), .err_timeout(tmo_c), .rx_total(rx_c)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(2);
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done_a); end
        n_checks++; if (error_a !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %0b want 0", error_a); end
        n_checks++; if (tmo_a !== 1'b0) begin n_fail++; $display("FAIL reset_err_timeout: got %0b want 0", tmo_a); end
        n_checks++; if (rx_a !== 32'd0) begin n_fail++; $display("FAIL reset_rx_total: got %0d want 0", rx_a); end
        n_checks++; if (dut_a.west_up_valid !== 2'b00) begin n_fail++; $display("FAIL reset_up_valid: got %b want 00", dut_a.west_up_valid); end
        n_checks++; if (dut_a.south_down_ready !== 2'b00) begin n_fail++; $display("FAIL reset_down_ready: got %b want 00", dut_a.south_down_ready); end
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_basic_pass;
        int cyc;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %0b want 1", busy_a); end
        n_checks++; if (dut_a.north_up_valid !== 2'b11) begin n_fail++; $display("FAIL basic_first_valid: got %b want 11", dut_a.north_up_valid); end
        cyc = 0;
        while (busy_a && cyc < 5000) begin tick(1); cyc++; end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_finish_bound: busy still %0b after %0d cycles, want 0", busy_a, cyc); end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b want 1", done_a); end
        n_checks++; if (error_a !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %0b want 0", error_a); end
        n_checks++; if (rx_a !== 32'd128) begin n_fail++; $display("FAIL basic_rx_total: got %0d want 128", rx_a); end
        n_checks++; if (cyc >= 4096) begin n_fail++; $display("FAIL basic_duration: got %0d want < 4096", cyc); end
    endtask

    task automatic test_mesh_3x4;
        int cyc;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        cyc = 0;
        while (busy_b && cyc < 5000) begin tick(1); cyc++; end
        n_checks++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL mesh3x4_done: got %0b want 1", done_b); end
        n_checks++; if (error_b !== 1'b0) begin n_fail++; $display("FAIL mesh3x4_error: got %0b want 0", error_b); end
        n_checks++; if (rx_b !== 32'd70) begin n_fail++; $display("FAIL mesh3x4_rx_total: got %0d want 70", rx_b); end
    endtask

    task automatic test_start_ignored;
        int cyc;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(6);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL ignored_busy: got %0b want 1", busy_a); end
        n_checks++; if (rx_a === 32'd0) begin n_fail++; $display("FAIL ignored_rx_not_cleared: got %0d want nonzero", rx_a); end
        cyc = 0;
        while (busy_a && cyc < 5000) begin tick(1); cyc++; end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL ignored_done: got %0b want 1", done_a); end
        n_checks++; if (rx_a !== 32'd128) begin n_fail++; $display("FAIL ignored_rx_total: got %0d want 128", rx_a); end
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n_checks++; if (rx_a !== 32'd0) begin n_fail++; $display("FAIL restart_rx_clear: got %0d want 0", rx_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL restart_done_clear: got %0b want 0", done_a); end
        cyc = 0;
        while (busy_a && cyc < 5000) begin tick(1); cyc++; end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %0b want 1", done_a); end
        n_checks++; if (rx_a !== 32'd128) begin n_fail++; $display("FAIL restart_rx_total: got %0d want 128", rx_a); end
    endtask

    task automatic test_check_error;
        int cyc;
        force dut_a.west_down_data = '0;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        cyc = 0;
        while (busy_a && cyc < 5000) begin tick(1); cyc++; end
        release dut_a.west_down_data;
        n_checks++; if (error_a !== 1'b1) begin n_fail++; $display("FAIL chkerr_error: got %0b want 1", error_a); end
        n_checks++; if (tmo_a !== 1'b0) begin n_fail++; $display("FAIL chkerr_err_timeout: got %0b want 0", tmo_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL chkerr_done: got %0b want 0", done_a); end
    endtask

    task automatic test_timeout;
        int cyc;
        start_c = 1'b1;
        tick(1);
        start_c = 1'b0;
        n_checks++; if (busy_c !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_rise: got %0b want 1", busy_c); end
        cyc = 0;
        while (!error_c && cyc < 1000) begin tick(1); cyc++; end
        n_checks++; if (cyc != 200) begin n_fail++; $display("FAIL timeout_latency: got %0d want 200", cyc); end
        n_checks++; if (tmo_c !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %0b want 1", tmo_c); end
        n_checks++; if (done_c !== 1'b0) begin n_fail++; $display("FAIL timeout_done: got %0b want 0", done_c); end
        n_checks++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_fall: got %0b want 0", busy_c); end
    endtask

    task automatic test_reset_midrun;
        int cyc;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(5);
        rst = 1'b0;
        #1;
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b want 0", busy_a); end
        n_checks++; if (rx_a !== 32'd0) begin n_fail++; $display("FAIL midrst_rx_total: got %0d want 0", rx_a); end
        n_checks++; if (dut_a.west_up_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_up_valid: got %b want 00", dut_a.west_up_valid); end
        n_checks++; if ({done_a, error_a, tmo_a} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b want 000", {done_a, error_a, tmo_a}); end
        tick(2);
        rst = 1'b1;
        tick(1);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        cyc = 0;
        while (busy_a && cyc < 5000) begin tick(1); cyc++; end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL midrst_pass_done: got %0b want 1", done_a); end
        n_checks++; if (error_a !== 1'b0) begin n_fail++; $display("FAIL midrst_pass_error: got %0b want 0", error_a); end
        n_checks++; if (rx_a !== 32'd128) begin n_fail++; $display("FAIL midrst_pass_rx_total: got %0d want 128", rx_a); end
    endtask

    initial begin
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        test_reset();
        test_basic_pass();
        test_mesh_3x4();
        test_start_ignored();
        test_check_error();
        test_timeout();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_mesh_tg_top.md
# noc_mesh_tg_top

Parametrised mesh top level: a MESH_WIDTH × MESH_HEIGHT mesh plus a built-in edge traffic generator/checker on every boundary port. It generalises the fixed 2×2 top, whose edge ports are left unconnected, into a self-testing top. On start, every edge port injects a burst of flits addressed to the opposite edge. Every edge port collects and checks the arriving flits. A global controller reports completion, error or timeout.

## Interface
- MESH_WIDTH, default 2: mesh columns, 1..16.
- MESH_HEIGHT, default 2: mesh rows, 1..16.
- PKT_COUNT, default 16: flits injected per edge port per run, 1..65535.
- TIMEOUT, default 4096: cycles allowed after start before a timeout is declared.
- clk  in  1: single clock; all logic is on rising edge.
- rst  in  1: asynchronous, active-low reset.
- start  in  1: one-cycle pulse; starts a run when idle, ignored otherwise.
- busy  out  1: a run is in progress.
- done  out  1: the last run passed; sticky until next start.
- error  out  1: the last run failed; sticky until next start.
- err_timeout  out  1: qualifies error; the failure was a timeout.
- rx_total  out  32: flits received and accepted by all edges in the current/last run.

## Operation
- node_port carries valid, ready and data[FLIT_W-1:0], where FLIT_W = 32.
  - *_up ports: edge → mesh; the generator is master.
  - *_down ports: mesh → edge; the checker is slave.
- Edge ids, N_EDGE = 2·(W+H):
  - west row r = r
  - east row r = H+r
  - north col c = 2H+c
  - south col c = 2H+W+c
- Flit fields: [31:24] dest id, [23:16] src id, [15:0] seq.
  - Dest is the opposite edge at the same index: west r ↔ east r, north c ↔ south c.
  - seq counts 0..PKT_COUNT-1.
- Global FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE --start--> RUN. Entering RUN clears rx_total, the timeout counter, done and error, and pulses go to every edge unit.
  - RUN → PASS when every edge unit reports tx_done and rx_done.
  - RUN → FAIL when any edge reports a check error, or when the timeout counter reaches TIMEOUT-1.
  - PASS and FAIL --start--> RUN. There is no automatic return to IDLE.
- Edge unit generator:
  - Drives valid=1 with the current seq from the go pulse until PKT_COUNT flits have been accepted.
  - seq increments only on valid&&ready.
  - data stays stable while valid&&!ready.
- Edge unit checker:
  - ready=1 whenever the global FSM is in RUN, and 0 otherwise.
  - Each accepted flit must satisfy dest==own id, src==opposite id and seq==expected. Expected starts at 0 and increments per flit; XY routing preserves order per source/dest pair.
  - Any mismatch raises a sticky check error.
  - rx_done is asserted once PKT_COUNT flits have been accepted.
  - A flit beyond PKT_COUNT is an error.
- rx_total is the sum of accepts across all edges, updated every cycle. Up to N_EDGE accepts per cycle; use a popcount adder.

## Timing
- Reset values:
  - FSM = IDLE.
  - busy, done, error, err_timeout = 0.
  - rx_total = 0.
  - All up valid = 0; all down ready = 0.
- start sampled in cycle t: busy=1 at t+1, and the first up valid is asserted at t+1.
- done or error is asserted in the cycle after the terminating condition; busy falls in that same cycle.
- A start while busy is ignored.
- Simultaneous timeout and completion in the same cycle resolves to PASS.
- Simultaneous check error and completion in the same cycle resolves to FAIL.
- When leaving RUN, generators drop valid immediately. A flit that is mid-handshake is abandoned; the next start restarts seq at 0.
- Reset mid-run returns everything to reset values within the asynchronous assertion. Deassertion is assumed synchronised externally.
- Timeout counter is 32 bits and saturates; it runs only in RUN.

## Structure
- Package noc_tg_pkg holds:
  - FLIT_W
  - flit_t, a packed struct with dest/src/seq
  - edge id helper functions
  - the tg_state_t enum
- One sub-module, noc_edge_tg: generator plus checker for one edge. Parameters MY_ID, PEER_ID, PKT_COUNT. Instantiated N_EDGE times in generate loops over rows and columns.
- The mesh is instantiated with node_port arrays sized MESH_HEIGHT and MESH_WIDTH.

## Test plan
- Default 2×2, PKT_COUNT=16, start pulse → done=1, error=0, rx_total=128, busy high for fewer than TIMEOUT cycles.
- 3×4 mesh, PKT_COUNT=5 → done=1, rx_total=70.
- Force one down port's data src field to a wrong value for one accept → error=1, err_timeout=0, done=0.
- Hold one down ready low via a force (stalled edge), TIMEOUT=200 → error=1 and err_timeout=1 exactly 200 cycles after busy rose.
- start pulsed again during RUN → ignored, rx_total unaffected. After PASS, start again → rx_total clears to 0, then returns to 128.
- Assert rst mid-run, release, then start → all outputs at reset values during reset, then a clean pass with rx_total=128.
